// File: rtl/qarbiter_pkg.sv
// Shared types for qarbiter. Sizing comes from QARBITER_NUM_IN / QARBITER_TDIN / QARBITER_LVL.
// QARBITER_FIXED_PRIO_EN (used by qarbiter) swaps round-robin for fixed lowest-index priority.
`ifndef QARBITER_NUM_IN
`define QARBITER_NUM_IN 4
`endif
`ifndef QARBITER_TDIN
`define QARBITER_TDIN 16
`endif
`ifndef QARBITER_LVL
`define QARBITER_LVL 1
`endif

package qarbiter_pkg;

  localparam int unsigned NUM_IN = `QARBITER_NUM_IN;
  localparam int unsigned TDIN   = `QARBITER_TDIN;
  localparam int unsigned LVL    = `QARBITER_LVL;
  localparam int unsigned CTRL_W = $clog2(NUM_IN);
  localparam int unsigned DIN_W  = LVL + TDIN;
  localparam int unsigned DOUT_W = CTRL_W + LVL + TDIN;

  typedef struct packed {
    logic [LVL-1:0]  eot;
    logic [TDIN-1:0] data;
  } din_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [LVL-1:0]    eot;
    logic [TDIN-1:0]   data;
  } dout_t;

  typedef enum logic [0:0] {IDLE, LOCKED} state_t;

  // Increment modulo n, safe for non-power-of-2 n.
  function automatic logic [CTRL_W-1:0] rr_next(input logic [CTRL_W-1:0] ptr, input int unsigned n);
    if (32'(ptr) + 32'd1 >= n) return '0;
    return CTRL_W'(32'(ptr) + 32'd1);
  endfunction

endpackage

// File: rtl/qarbiter_if.sv
// Valid/ready queue link carrying a W-bit element; producer/consumer plus master/slave aliases.
interface qarbiter_if #(parameter int unsigned W = 1) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
  modport master   (output valid, output data, input ready);
  modport slave    (input valid, input data, output ready);
endinterface

// File: rtl/qarbiter_rr_pick.sv
// Rotating-priority encoder: first set bit of i_valid at or after i_ptr, wrapping at NUM_IN.
module qarbiter_rr_pick
  import qarbiter_pkg::*;
(
  input  logic [NUM_IN-1:0] i_valid,
  input  logic [CTRL_W-1:0] i_ptr,
  output logic [CTRL_W-1:0] o_idx_c,
  output logic              o_any_c
);

  logic [CTRL_W-1:0] w_scan;

  always_comb begin
    o_idx_c = '0;
    o_any_c = 1'b0;
    w_scan  = i_ptr;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (!o_any_c && i_valid[w_scan]) begin
        o_idx_c = w_scan;
        o_any_c = 1'b1;
      end
      w_scan = rr_next(w_scan, NUM_IN);
    end
  end

endmodule

// File: rtl/qarbiter.sv
// Round-robin queue arbiter: locks one input for a whole transaction, appends its index as ctrl.
// Define QARBITER_FIXED_PRIO_EN for fixed lowest-index priority between transactions.
module qarbiter
  import qarbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  qarbiter_if.consumer  din [NUM_IN],
  qarbiter_if.producer  dout
);

  logic [NUM_IN-1:0] w_valid;
  logic [NUM_IN-1:0] w_ready;
  din_t              w_data [NUM_IN];

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
    assign w_valid[gi]    = din[gi].valid;
    assign w_data[gi]     = din_t'(din[gi].data);
    assign din[gi].ready  = w_ready[gi];
  end

  state_t            r_state, w_state_nxt;
  logic [CTRL_W-1:0] r_grant, w_grant_nxt;
  logic [CTRL_W-1:0] w_pick_ptr, w_pick_idx, w_g;
  logic              w_pick_any, w_hs, w_last, w_out_valid;
  dout_t             w_out;

`ifdef QARBITER_FIXED_PRIO_EN
  assign w_pick_ptr = '0;
`else
  logic [CTRL_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  assign w_pick_ptr = r_rr_ptr;
`endif

  qarbiter_rr_pick u_pick (
    .i_valid (w_valid),
    .i_ptr   (w_pick_ptr),
    .o_idx_c (w_pick_idx),
    .o_any_c (w_pick_any)
  );

  // Zero-latency forwarding from the current grant plus next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
`ifndef QARBITER_FIXED_PRIO_EN
    w_rr_ptr_nxt = r_rr_ptr;
`endif
    w_g         = (r_state == LOCKED) ? r_grant : w_pick_idx;
    w_ready     = '0;
    w_out_valid = 1'b0;
    w_out       = '0;
    if (rst && (r_state == LOCKED || w_pick_any)) begin
      w_out_valid  = w_valid[w_g];
      w_ready[w_g] = dout.ready;
      w_out.ctrl   = w_g;
      w_out.eot    = w_data[w_g].eot;
      w_out.data   = w_data[w_g].data;
    end
    w_hs   = w_out_valid & dout.ready;
    w_last = &w_out.eot;
    case (r_state)
      IDLE: begin
        if (w_hs && !w_last) begin
          w_state_nxt = LOCKED;
          w_grant_nxt = w_g;
        end
      end
      LOCKED: begin
        if (w_hs && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
`ifndef QARBITER_FIXED_PRIO_EN
    // w_g equals r_grant while locked, so one update covers both end-of-transaction cases.
    if (w_hs && w_last) w_rr_ptr_nxt = rr_next(w_g, NUM_IN);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_grant  <= '0;
`ifndef QARBITER_FIXED_PRIO_EN
      r_rr_ptr <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
`ifndef QARBITER_FIXED_PRIO_EN
      r_rr_ptr <= w_rr_ptr_nxt;
`endif
    end
  end

  assign dout.valid = w_out_valid;
  assign dout.data  = w_out;

endmodule

// File: tb/tb_qarbiter.sv
// Bench for qarbiter: directed scenarios with literal expectations plus a randomized run against a transaction-level model.
module tb_qarbiter;
  import qarbiter_pkg::*;

`ifdef QARBITER_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qarbiter_if #(.W(DIN_W))  din_if [NUM_IN] ();
  qarbiter_if #(.W(DOUT_W)) dout_if ();

  logic [NUM_IN-1:0] tb_valid;
  logic [NUM_IN-1:0] dut_ready;
  din_t              tb_data [NUM_IN];
  logic              tb_oready;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_drv
    assign din_if[gi].valid = tb_valid[gi];
    assign din_if[gi].data  = tb_data[gi];
    assign dut_ready[gi]    = din_if[gi].ready;
  end
  assign dout_if.ready = tb_oready;

  qarbiter u_dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din_if),
    .dout (dout_if)
  );

  int n_cmp = 0;
  int n_err = 0;
  int beats[$];
  int m_open, m_holder, m_ptr;
  din_t txq [NUM_IN][$];
  int done_cnt [NUM_IN];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_beats(input string name, input int exp[$]);
    chk({name, "_count"}, 64'(beats.size()), 64'(exp.size()));
    for (int k = 0; k < exp.size() && k < beats.size(); k++)
      chk(name, 64'(beats[k]), 64'(exp[k]));
  endtask

  // Model: holder of an open transaction, else first offering input from the pointer upward.
  function automatic int m_pick();
    int i;
    if (m_open != 0) return m_holder;
    for (int k = 0; k < int'(NUM_IN); k++) begin
      i = (m_ptr + k) % int'(NUM_IN);
      if (tb_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic step(output bit hs, output int hg, output bit dv, output dout_t dd, output logic [NUM_IN-1:0] rv);
    int                g;
    bit                ev;
    logic [NUM_IN-1:0] er;
    dout_t             ed;
    @(negedge clk);
    g  = m_pick();
    ev = (rst === 1'b1) && (g >= 0) && tb_valid[g];
    er = '0;
    if (rst === 1'b1 && g >= 0) er[g] = tb_oready;
    chk("dout_valid", 64'(dout_if.valid), 64'(ev));
    chk("din_ready", 64'(dut_ready), 64'(er));
    if (ev) begin
      ed.ctrl = CTRL_W'(g);
      ed.eot  = tb_data[g].eot;
      ed.data = tb_data[g].data;
      chk("dout_data", 64'(dout_if.data), 64'(ed));
    end
    dv = dout_if.valid;
    dd = dout_t'(dout_if.data);
    rv = dut_ready;
    if (dv && tb_oready) beats.push_back(int'(dd.ctrl));
    hs = ev && tb_oready;
    hg = g;
    @(posedge clk);
    if (hs) begin
      if (&tb_data[g].eot) begin
        m_open = 0;
        m_ptr  = FIXED ? 0 : (g + 1) % int'(NUM_IN);
        done_cnt[g]++;
      end else if (m_open == 0) begin
        m_open   = 1;
        m_holder = g;
      end
    end
    #1;
  endtask

  task automatic put(input int i, input logic [LVL-1:0] e, input int dat);
    tb_valid[i]     = 1'b1;
    tb_data[i].eot  = e;
    tb_data[i].data = TDIN'(dat);
  endtask

  bit                hs, dv;
  int                hg;
  dout_t             dd, ed;
  logic [NUM_IN-1:0] rv;
  int                exp_q[$];
  logic [LVL-1:0]    e;
  int                len;

  initial begin
    rst = 1'b0; tb_valid = '0; tb_oready = 1'b1;
    m_open = 0; m_holder = 0; m_ptr = 0;
    for (int i = 0; i < int'(NUM_IN); i++) begin tb_data[i] = '0; done_cnt[i] = 0; end

    // Reset holds everything quiet even with all inputs offering.
    tb_valid = '1;
    #12;
    chk("rst_valid", 64'(dout_if.valid), 64'(0));
    chk("rst_ready", 64'(dut_ready), 64'(0));
    @(posedge clk); #1 rst = 1'b1;
    tb_valid = '0;

    // Single requester, three-element queue on input 2.
    beats.delete();
    for (int k = 0; k < 3; k++) begin
      put(2, (k == 2) ? '1 : '0, 16'hA0 + k);
      step(hs, hg, dv, dd, rv);
      chk("single_beat", 64'({dv, dd.ctrl}), 64'({1'b1, CTRL_W'(2)}));
    end
    tb_valid = '0;

    // All inputs offering single-element queues: rotation continues after input 2.
    beats.delete();
    for (int i = 0; i < int'(NUM_IN); i++) put(i, '1, 16'h1000 * (i + 1));
    for (int k = 0; k < 7; k++) step(hs, hg, dv, dd, rv);
    tb_valid = '0;
    exp_q = FIXED ? '{0, 0, 0, 0, 0, 0, 0} : '{3, 0, 1, 2, 3, 0, 1};
    chk_beats("fair_order", exp_q);

    // Locking: input 0 stalls mid-transaction, input 1 must wait.
    beats.delete();
    put(0, '0, 16'h10); put(1, '1, 16'h11);
    step(hs, hg, dv, dd, rv);
    tb_valid[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step(hs, hg, dv, dd, rv);
      chk("lock_stall_valid", 64'(dv), 64'(0));
    end
    put(0, '0, 16'h12); step(hs, hg, dv, dd, rv);
    put(0, '1, 16'h13); step(hs, hg, dv, dd, rv);
    tb_valid[0] = 1'b0;
    step(hs, hg, dv, dd, rv);
    tb_valid = '0;
    exp_q = '{0, 0, 0, 1};
    chk_beats("lock_order", exp_q);

    // Backpressure on input 3.
    beats.delete();
    put(3, '1, 16'h3C3C);
    tb_oready = 1'b0;
    ed.ctrl = CTRL_W'(3); ed.eot = '1; ed.data = 16'h3C3C;
    for (int k = 0; k < 5; k++) begin
      step(hs, hg, dv, dd, rv);
      chk("bp_valid", 64'(dv), 64'(1));
      chk("bp_data", 64'(dd), 64'(ed));
      chk("bp_ready3", 64'(rv[3]), 64'(0));
    end
    tb_oready = 1'b1;
    step(hs, hg, dv, dd, rv);
    tb_valid = '0;
    exp_q = '{3};
    chk_beats("bp_release", exp_q);

    // Partial eot patterns must not release the lock.
    beats.delete();
    put(1, (LVL == 1) ? '0 : LVL'(1), 16'h21);
    step(hs, hg, dv, dd, rv);
    put(0, '1, 16'h20);
    for (int k = 1; k < 4; k++) begin
      if (k == 3)      e = '1;
      else if (k == 2) e = (LVL == 1) ? '0 : ~LVL'(1);
      else             e = (LVL == 1) ? '0 : LVL'(1);
      put(1, e, 16'h21 + k);
      step(hs, hg, dv, dd, rv);
    end
    tb_valid[1] = 1'b0;
    step(hs, hg, dv, dd, rv);
    tb_valid = '0;
    exp_q = '{1, 1, 1, 1, 0};
    chk_beats("eot_lock", exp_q);

    // Asynchronous reset while locked on input 2.
    put(2, '0, 16'h31);
    step(hs, hg, dv, dd, rv);
    put(2, '0, 16'h32); put(0, '1, 16'h40); put(1, '1, 16'h41); put(3, '1, 16'h43);
    #2;
    chk("pre_rst_valid", 64'(dout_if.valid), 64'(1));
    rst = 1'b0; m_open = 0; m_ptr = 0;
    #1;
    chk("async_rst_valid", 64'(dout_if.valid), 64'(0));
    chk("async_rst_ready", 64'(dut_ready), 64'(0));
    @(posedge clk); #1 rst = 1'b1;
    tb_data[2].eot = '1;
    beats.delete();
    step(hs, hg, dv, dd, rv);
    tb_valid = '0;
    exp_q = '{0};
    chk_beats("post_rst_grant", exp_q);

    // Randomized producers obeying hold-until-accepted.
    for (int i = 0; i < int'(NUM_IN); i++) begin txq[i].delete(); done_cnt[i] = 0; end
    for (int c = 0; c < 2000; c++) begin
      tb_oready = ($urandom % 4) != 0;
      step(hs, hg, dv, dd, rv);
      for (int i = 0; i < int'(NUM_IN); i++) begin
        if (hs && hg == i) begin
          tb_valid[i] = 1'b0;
          void'(txq[i].pop_front());
        end
        if (!tb_valid[i]) begin
          if (txq[i].size() == 0 && ($urandom % 3) == 0) begin
            len = int'($urandom_range(1, 4));
            for (int k = 0; k < len; k++) begin
              e = LVL'($urandom);
              if (&e) e[0] = 1'b0;
              if (k == len - 1) e = '1;
              txq[i].push_back('{eot: e, data: TDIN'($urandom)});
            end
          end
          if (txq[i].size() != 0 && ($urandom % 4) != 0) begin
            tb_valid[i] = 1'b1;
            tb_data[i]  = txq[i][0];
          end
        end
      end
    end
    for (int i = 0; i < int'(NUM_IN); i++)
      chk("rand_progress", 64'(done_cnt[i] > 0), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
